// File: rtl/out_sel_rr_enc.sv
// Registered one-hot-to-index encoder with fixed-priority or round-robin selection and a valid/ready handshake.
// Optional macro OUT_SEL_MULTIHOT_CHK_EN flags multi-hot allocations and counts them as errors.
module out_sel_rr_enc #(
  parameter int NUM_PORT     = 5,
  parameter int LOG_NUM_PORT = 3,
  parameter int PRIO_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_PORT-1:0]     alloc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LOG_NUM_PORT-1:0] out_sel,
  output logic                    out_none,
  output logic [7:0]              err_cnt,
  output logic                    err_multi
);

  localparam logic [LOG_NUM_PORT-1:0] LAST_PORT = LOG_NUM_PORT'(NUM_PORT - 1);

  logic [LOG_NUM_PORT-1:0] ptr;
  logic [LOG_NUM_PORT-1:0] win;
  logic [LOG_NUM_PORT-1:0] idx;
  logic                    found;
  logic                    accept;
  logic                    zero;
  logic                    multi_err;
  logic                    err_inc;
  int                      pos;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign zero     = (alloc == '0);

`ifdef OUT_SEL_MULTIHOT_CHK_EN
  logic err_multi_q;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi_err = |(alloc & (alloc - NUM_PORT'(1)));
  assign err_multi = err_multi_q;
`else
  assign multi_err = 1'b0;
  assign err_multi = 1'b0;
`endif

  assign err_inc = zero || multi_err;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    if (PRIO_MODE == 0) begin
      for (int i = 0; i < NUM_PORT; i++) begin
        if (alloc[i]) begin
          win = LOG_NUM_PORT'(i);
        end
      end
    end else begin
      // Walk downward from ptr, wrapping from 0 back to the last port.
      for (int i = 0; i < NUM_PORT; i++) begin
        pos = int'(ptr) - i;
        if (pos < 0) begin
          pos = pos + NUM_PORT;
        end
        idx = LOG_NUM_PORT'(pos);
        if (!found && pos < NUM_PORT && alloc[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_none  <= 1'b0;
      err_cnt   <= '0;
      ptr       <= LAST_PORT;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_sel   <= zero ? '1 : win;
        out_none  <= zero;
        if (!zero) begin
          ptr <= (win == '0) ? LAST_PORT : win - LOG_NUM_PORT'(1);
        end
        if (err_inc && err_cnt != 8'hff) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef OUT_SEL_MULTIHOT_CHK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_multi_q <= 1'b0;
    end else if (accept) begin
      err_multi_q <= multi_err;
    end
  end
`endif

endmodule

// File: tb/tb_out_sel_rr_enc.sv
// Directed bench for out_sel_rr_enc: one fixed-priority and one round-robin instance driven by shared inputs.
module tb_out_sel_rr_enc;

`ifdef OUT_SEL_MULTIHOT_CHK_EN
  localparam bit MH = 1'b1;
`else
  localparam bit MH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [4:0] alloc = '0;

  logic       in_ready0, out_valid0, out_none0, err_multi0;
  logic [2:0] out_sel0;
  logic [7:0] err_cnt0;
  logic       in_ready1, out_valid1, out_none1, err_multi1;
  logic [2:0] out_sel1;
  logic [7:0] err_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  out_sel_rr_enc #(.NUM_PORT(5), .LOG_NUM_PORT(3), .PRIO_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .alloc(alloc), .out_valid(out_valid0), .out_ready(out_ready),
    .out_sel(out_sel0), .out_none(out_none0), .err_cnt(err_cnt0), .err_multi(err_multi0)
  );

  out_sel_rr_enc #(.NUM_PORT(5), .LOG_NUM_PORT(3), .PRIO_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .alloc(alloc), .out_valid(out_valid1), .out_ready(out_ready),
    .out_sel(out_sel1), .out_none(out_none1), .err_cnt(err_cnt1), .err_multi(err_multi1)
  );

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alloc = '0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_checks++;
    if ({out_valid0, out_sel0, out_none0, err_multi0, err_cnt0, in_ready0} !== {1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      $display("FAIL reset_dut0 got v=%b sel=%0d none=%b em=%b cnt=%0d rdy=%b expected 0 0 0 0 0 1",
               out_valid0, out_sel0, out_none0, err_multi0, err_cnt0, in_ready0);
      n_fail++;
    end
    n_checks++;
    if ({out_valid1, out_sel1, out_none1, err_multi1, err_cnt1, in_ready1} !== {1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      $display("FAIL reset_dut1 got v=%b sel=%0d none=%b em=%b cnt=%0d rdy=%b expected 0 0 0 0 0 1",
               out_valid1, out_sel1, out_none1, err_multi1, err_cnt1, in_ready1);
      n_fail++;
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [4:0] vec [3];
    logic [2:0] exp0 [3];
    logic [2:0] exp1 [3];
    vec  = '{5'b10000, 5'b00100, 5'b00001};
    exp0 = '{3'd4, 3'd2, 3'd0};
    exp1 = '{3'd4, 3'd2, 3'd0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alloc = vec[i];
      step();
      n_checks++;
      if ({out_valid0, out_sel0, out_none0} !== {1'b1, exp0[i], 1'b0}) begin
        $display("FAIL b2b_dut0[%0d] got v=%b sel=%0d none=%b expected 1 %0d 0", i, out_valid0, out_sel0, out_none0, exp0[i]);
        n_fail++;
      end
      n_checks++;
      if ({out_valid1, out_sel1, out_none1} !== {1'b1, exp1[i], 1'b0}) begin
        $display("FAIL b2b_dut1[%0d] got v=%b sel=%0d none=%b expected 1 %0d 0", i, out_valid1, out_sel1, out_none1, exp1[i]);
        n_fail++;
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if ({out_valid0, out_valid1} !== 2'b00) begin
      $display("FAIL b2b_drain got v0=%b v1=%b expected 0 0", out_valid0, out_valid1);
      n_fail++;
    end
  endtask

  task automatic test_multihot();
    // dut1 pointer is 4 here, so its search 4,3 also lands on 3.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alloc     = 5'b01010;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid0, out_sel0, err_multi0, err_cnt0} !== {1'b1, 3'd3, MH, 8'(MH)}) begin
      $display("FAIL multihot_dut0 got v=%b sel=%0d em=%b cnt=%0d expected 1 3 %b %0d", out_valid0, out_sel0, err_multi0, err_cnt0, MH, MH);
      n_fail++;
    end
    n_checks++;
    if ({out_valid1, out_sel1, err_multi1, err_cnt1} !== {1'b1, 3'd3, MH, 8'(MH)}) begin
      $display("FAIL multihot_dut1 got v=%b sel=%0d em=%b cnt=%0d expected 1 3 %b %0d", out_valid1, out_sel1, err_multi1, err_cnt1, MH, MH);
      n_fail++;
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp1 [6];
    exp1 = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alloc     = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if ({out_valid1, out_sel1} !== {1'b1, exp1[i]}) begin
        $display("FAIL rr_dut1[%0d] got v=%b sel=%0d expected 1 %0d", i, out_valid1, out_sel1, exp1[i]);
        n_fail++;
      end
      n_checks++;
      if ({out_valid0, out_sel0} !== {1'b1, 3'd4}) begin
        $display("FAIL rr_dut0[%0d] got v=%b sel=%0d expected 1 4", i, out_valid0, out_sel0);
        n_fail++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (err_cnt1 !== (MH ? 8'd6 : 8'd0)) begin
      $display("FAIL rr_errcnt got %0d expected %0d", err_cnt1, MH ? 6 : 0);
      n_fail++;
    end
    step();
  endtask

  task automatic test_hold();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alloc     = 5'b01000;
    step();
    out_ready = 1'b0;
    alloc     = 5'b00001;
    #1;
    n_checks++;
    if ({in_ready0, in_ready1} !== 2'b00) begin
      $display("FAIL hold_ready got r0=%b r1=%b expected 0 0", in_ready0, in_ready1);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({out_valid0, out_sel0, in_ready0, out_valid1, out_sel1, in_ready1} !== {1'b1, 3'd3, 1'b0, 1'b1, 3'd3, 1'b0}) begin
        $display("FAIL hold[%0d] got v0=%b s0=%0d r0=%b v1=%b s1=%0d r1=%b expected 1 3 0 1 3 0",
                 i, out_valid0, out_sel0, in_ready0, out_valid1, out_sel1, in_ready1);
        n_fail++;
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if ({in_ready0, in_ready1} !== 2'b11) begin
      $display("FAIL hold_release_ready got r0=%b r1=%b expected 1 1", in_ready0, in_ready1);
      n_fail++;
    end
    step();
    in_valid = 1'b0;
    // dut1: ptr moved to 2 after winner 3, search 2,1,0 finds 0.
    n_checks++;
    if ({out_valid0, out_sel0, out_valid1, out_sel1} !== {1'b1, 3'd0, 1'b1, 3'd0}) begin
      $display("FAIL hold_next got v0=%b s0=%0d v1=%b s1=%0d expected 1 0 1 0", out_valid0, out_sel0, out_valid1, out_sel1);
      n_fail++;
    end
    step();
    n_checks++;
    if ({out_valid0, out_valid1} !== 2'b00) begin
      $display("FAIL hold_drain got v0=%b v1=%b expected 0 0", out_valid0, out_valid1);
      n_fail++;
    end
  endtask

  task automatic test_zero_sat();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alloc     = 5'b00000;
    step();
    n_checks++;
    if ({out_valid0, out_sel0, out_none0, err_cnt0} !== {1'b1, 3'b111, 1'b1, 8'd1}) begin
      $display("FAIL zero_dut0 got v=%b sel=%0d none=%b cnt=%0d expected 1 7 1 1", out_valid0, out_sel0, out_none0, err_cnt0);
      n_fail++;
    end
    n_checks++;
    if ({out_valid1, out_sel1, out_none1, err_cnt1} !== {1'b1, 3'b111, 1'b1, 8'd1}) begin
      $display("FAIL zero_dut1 got v=%b sel=%0d none=%b cnt=%0d expected 1 7 1 1", out_valid1, out_sel1, out_none1, err_cnt1);
      n_fail++;
    end
    for (int i = 0; i < 254; i++) step();
    n_checks++;
    if ({err_cnt0, err_cnt1} !== {8'd255, 8'd255}) begin
      $display("FAIL zero_255 got c0=%0d c1=%0d expected 255 255", err_cnt0, err_cnt1);
      n_fail++;
    end
    step();
    n_checks++;
    if ({err_cnt0, err_cnt1} !== {8'd255, 8'd255}) begin
      $display("FAIL zero_sat got c0=%0d c1=%0d expected 255 255", err_cnt0, err_cnt1);
      n_fail++;
    end
    // Zero beats must not have moved the round-robin pointer off 4.
    alloc = 5'b11111;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_sel1, out_none1} !== {3'd4, 1'b0}) begin
      $display("FAIL zero_ptr got sel=%0d none=%b expected 4 0", out_sel1, out_none1);
      n_fail++;
    end
    step();
  endtask

  task automatic test_reset_mid_beat();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alloc     = 5'b11111;
    step();
    alloc     = 5'b01000;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    n_checks++;
    if ({out_valid1, out_sel1} !== {1'b1, 3'd3}) begin
      $display("FAIL rstmid_pre got v=%b sel=%0d expected 1 3", out_valid1, out_sel1);
      n_fail++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid0, out_valid1} !== 2'b00) begin
      $display("FAIL rstmid_async got v0=%b v1=%b expected 0 0", out_valid0, out_valid1);
      n_fail++;
    end
    step();
    reset_n = 1'b1;
    step();
    n_checks++;
    if ({out_valid0, out_valid1} !== 2'b00) begin
      $display("FAIL rstmid_release got v0=%b v1=%b expected 0 0", out_valid0, out_valid1);
      n_fail++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alloc     = 5'b11111;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid1, out_sel1} !== {1'b1, 3'd4}) begin
      $display("FAIL rstmid_first got v=%b sel=%0d expected 1 4", out_valid1, out_sel1);
      n_fail++;
    end
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_multihot();
    test_round_robin();
    test_hold();
    test_zero_sat();
    test_reset_mid_beat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/out_sel_rr_enc.md
OUT_SEL_RR_ENC -- requirements
Module: out_sel_rr_enc

Interface
REQ-001 Parameter NUM_PORT, default 5: width of the allocation vector (output ports).
REQ-002 Parameter LOG_NUM_PORT, default 3: width of the encoded port index; SHALL satisfy 2^LOG_NUM_PORT > NUM_PORT.
REQ-003 Parameter PRIO_MODE, default 0: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  alloc is presented.
REQ-007 in_ready  output  1  block can accept alloc this cycle.
REQ-008 alloc  input  NUM_PORT  port allocation vector, nominally one-hot.
REQ-009 out_valid  output  1  out_sel/out_none hold a result.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 out_sel  output  LOG_NUM_PORT  selected port index; all-ones when alloc was zero.
REQ-012 out_none  output  1  registered result came from an all-zero alloc.
REQ-013 err_cnt  output  8  saturating count of erroneous accepted allocs.
REQ-014 err_multi  output  1  registered result came from a multi-hot alloc.

Function
REQ-015 in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-016 Accept = in_valid && in_ready; the encoded result SHALL appear on out_sel/out_none/err_multi with out_valid=1 on the next cycle (latency 1).
REQ-017 While out_valid && !out_ready, out_sel, out_none and err_multi SHALL hold stable.
REQ-018 Consume without accept SHALL clear out_valid next cycle; consume with accept in the same cycle SHALL load the new result with no bubble.
REQ-019 PRIO_MODE=0: out_sel = highest set bit index of alloc.
REQ-020 PRIO_MODE=1: search order ptr, ptr-1, ..., 0, NUM_PORT-1, ... (wrapping); the first set bit wins.
REQ-021 ptr (LOG_NUM_PORT bits) SHALL update only on accept with nonzero alloc, to winner-1, or NUM_PORT-1 when the winner is 0.
REQ-022 Zero alloc on accept: out_sel = all ones, out_none = 1, ptr unchanged, err_cnt increments.
REQ-023 err_cnt SHALL saturate at 255; at most +1 per accepted beat.
REQ-024 in_valid while !in_ready SHALL have no effect on any state.

Reset
REQ-025 On reset_n low (asynchronous): out_valid=0, out_sel=0, out_none=0, err_multi=0, err_cnt=0, ptr=NUM_PORT-1; in_ready therefore reads 1.
REQ-026 Reset during a held beat SHALL discard that beat; no partial result is emitted after release.

Configuration
REQ-027 Macro OUT_SEL_MULTIHOT_CHK_EN defined: popcount(alloc)>1 on accept SHALL set err_multi=1 for that result and increment err_cnt; encoding still follows REQ-019/020.
REQ-028 Macro undefined: err_multi SHALL be tied 0; multi-hot allocs SHALL be encoded silently with no err_cnt change.

Verification
REQ-029 PRIO_MODE=0, out_ready=1, allocs 5'b10000, 5'b00100, 5'b00001 back-to-back -> out_sel 4, 2, 0 on consecutive cycles with out_valid continuously 1.
REQ-030 alloc 5'b00000 accepted -> out_sel=3'b111, out_none=1, err_cnt 0->1; 256 such beats -> err_cnt holds at 255.
REQ-031 PRIO_MODE=1, alloc 5'b11111 four times -> out_sel 4, 3, 2, 1; a fifth time -> 0; a sixth time -> 4 (wrap).
REQ-032 out_ready=0 for 3 cycles after the result of 5'b01000 -> out_sel=3 held, in_ready=0, a new in_valid ignored; out_ready=1 -> the pending input is accepted in the same cycle.
REQ-033 With OUT_SEL_MULTIHOT_CHK_EN, alloc 5'b01010 in PRIO_MODE=0 -> out_sel=3, err_multi=1, err_cnt +1; without the macro -> out_sel=3, err_multi=0, err_cnt unchanged.
REQ-034 reset_n asserted while out_valid=1 and out_ready=0 -> out_valid=0 immediately; after release the first alloc 5'b11111 in PRIO_MODE=1 yields out_sel=4.
